input_pio_capture: RTL and testbench
====================================

INPUT_PIO_CAPTURE -- requirements
Module: input_pio_capture

Interface
REQ-001 Parameter WIDTH, default 10, number of input channels; legal range 1..32.
REQ-002 Parameter EDGE_MODE, default 0, capture edge: 0 rising, 1 falling, 2 any.
REQ-003 Parameter SYNC_STAGES, default 2, input synchronizer depth; legal range 2..4.
REQ-004 Parameter DEBOUNCE_CYCLES, default 1000, debounce qualification length in clk cycles; used only when PIO_DEBOUNCE_EN is defined.
REQ-005 clk  input  1  system clock; all state updates on its rising edge.
REQ-006 reset_n  input  1  reset, asynchronous, active-low.
REQ-007 address  input  2  Avalon-MM word address.
REQ-008 chipselect  input  1  slave select; qualifies writes.
REQ-009 write_n  input  1  active-low write strobe.
REQ-010 writedata  input  32  write data.
REQ-011 in_port  input  WIDTH  asynchronous external inputs (switches/keys).
REQ-012 readdata  output  32  registered read data.
REQ-013 irq  output  1  level interrupt, active-high.

Function
REQ-014 in_port SHALL pass through a SYNC_STAGES-deep per-bit flop chain; its output is "sync".
REQ-015 Without debounce, the filtered value "filt" SHALL equal sync.
REQ-016 Register map: 0 data (RO, filt), 1 reserved (reads 0, writes ignored), 2 irq_mask (RW, WIDTH bits), 3 edge_capture (RO, write-1-to-clear).
REQ-017 readdata SHALL register, every cycle regardless of chipselect, the word selected by address; one-cycle read latency; bits 31..WIDTH read 0.
REQ-018 Write occurs when chipselect=1 and write_n=0 at a clk edge; irq_mask takes writedata[WIDTH-1:0] in that cycle.
REQ-019 prev SHALL hold filt delayed one cycle; edge for bit i is filt&~prev (mode 0), ~filt&prev (mode 1), filt^prev (mode 2).
REQ-020 A detected edge SHALL set edge_capture[i] on the next clk edge; the bit stays set until cleared.
REQ-021 Write to address 3 with writedata[i]=1 SHALL clear edge_capture[i]; bits written 0 unchanged.
REQ-022 Simultaneous edge and clear on the same bit: set wins, bit remains 1.
REQ-023 irq SHALL equal OR of (edge_capture & irq_mask), combinational from flops; no added latency.
REQ-024 Edge detection SHALL be disarmed after reset until an arm counter has counted SYNC_STAGES+1 cycles; while disarmed prev tracks filt and no capture occurs.

Reset
REQ-025 reset_n low SHALL asynchronously clear sync chain, prev, irq_mask, edge_capture, readdata, arm counter, and debounce state; irq therefore 0.
REQ-026 Reset asserted mid-operation SHALL discard pending edges; no edge is captured for inputs already high when reset releases.

Configuration
REQ-027 Macro PIO_DEBOUNCE_EN defined: each channel SHALL have a counter of clog2(DEBOUNCE_CYCLES+1) bits; filt[i] toggles only after sync[i] differs from filt[i] for DEBOUNCE_CYCLES consecutive cycles; any cycle with sync[i]==filt[i] zeroes the counter; filt resets to 0.
REQ-028 Macro PIO_DEBOUNCE_EN undefined: no debounce counters are synthesized; filt=sync, DEBOUNCE_CYCLES ignored.

Verification
REQ-029 WIDTH=10, in_port=10'h2A5 held -> readdata at address 0 equals 32'h0000_02A5 within SYNC_STAGES+2 cycles; address 1 reads 0.
REQ-030 EDGE_MODE=0, mask=10'h001, in_port[0] 0->1 -> edge_capture=0x001, irq=1; write 0x001 to address 3 -> irq=0 next cycle.
REQ-031 EDGE_MODE=1, in_port[3] 1->0 and [4] 0->1 -> edge_capture=0x008 only; mask=0 keeps irq=0.
REQ-032 Edge on bit 2 in the same cycle as write-1-clear of bit 2 -> edge_capture[2] remains 1.
REQ-033 in_port=10'h3FF held through reset release -> edge_capture stays 0, irq stays 0.
REQ-034 PIO_DEBOUNCE_EN, DEBOUNCE_CYCLES=8: 5-cycle glitch on in_port[1] -> no filt change, no capture; 8+ cycle level -> filt[1]=1, edge captured.

Source files
------------

// File: rtl/input_pio_capture.sv
// Avalon-MM input PIO: per-bit synchronizer, edge capture with write-1-to-clear and level IRQ.
// Optional per-channel debounce filter is built when PIO_DEBOUNCE_EN is defined.
`timescale 1ns/1ps
module input_pio_capture #(
  parameter int WIDTH           = 10,
  parameter int EDGE_MODE       = 0,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  typedef enum logic [1:0] {
    ADDR_DATA = 2'd0,
    ADDR_RSVD = 2'd1,
    ADDR_MASK = 2'd2,
    ADDR_EDGE = 2'd3
  } reg_addr_e;

  localparam int ARM_COUNT = SYNC_STAGES + 1;
  localparam int ARM_W     = $clog2(ARM_COUNT + 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] filt;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] clear_bits;
  logic [ARM_W-1:0] arm_cnt;
  logic             armed;
  logic             wr_en;
  logic [31:0]      rd_word;
  logic             unused_cfg;

  // NOTE: state flops use non-blocking assignments and an asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

`ifdef PIO_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  for (genvar i = 0; i < WIDTH; i++) begin : g_debounce
    logic [CNT_W-1:0] db_cnt;
    logic             filt_bit;

    // NOTE: every debounce counter is reset, so no channel starts mid-qualification.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        db_cnt   <= '0;
        filt_bit <= 1'b0;
      end else if (sync[i] == filt_bit) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_cnt   <= '0;
        filt_bit <= ~filt_bit;
      end else begin
        db_cnt <= db_cnt + CNT_W'(1);
      end
    end

    assign filt[i] = filt_bit;
  end

  assign unused_cfg = ^writedata;
`else
  assign filt       = sync;
  assign unused_cfg = ^{writedata, 32'(DEBOUNCE_CYCLES)};
`endif

  // Edge detection stays disarmed until the synchronizer has flushed its reset zeros.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      arm_cnt <= '0;
    end else if (!armed) begin
      arm_cnt <= arm_cnt + ARM_W'(1);
    end
  end

  assign armed = (arm_cnt == ARM_W'(ARM_COUNT));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev <= '0;
    end else begin
      prev <= filt;
    end
  end

  if (EDGE_MODE == 0) begin : g_rise
    assign edge_det = filt & ~prev;
  end else if (EDGE_MODE == 1) begin : g_fall
    assign edge_det = ~filt & prev;
  end else begin : g_any
    assign edge_det = filt ^ prev;
  end

  assign wr_en      = chipselect & ~write_n;
  assign clear_bits = (wr_en && (address == ADDR_EDGE)) ? writedata[WIDTH-1:0] : '0;

  // A new edge is OR-ed in after the clear, so set wins on a simultaneous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_capture <= '0;
      irq_mask     <= '0;
    end else begin
      edge_capture <= (edge_capture & ~clear_bits) | (armed ? edge_det : '0);
      if (wr_en && (address == ADDR_MASK)) begin
        irq_mask <= writedata[WIDTH-1:0];
      end
    end
  end

  // NOTE: rd_word is given a default before the case so no latch is inferred.
  always_comb begin
    rd_word = '0;
    case (reg_addr_e'(address))
      ADDR_DATA: rd_word[WIDTH-1:0] = filt;
      ADDR_MASK: rd_word[WIDTH-1:0] = irq_mask;
      ADDR_EDGE: rd_word[WIDTH-1:0] = edge_capture;
      default:   rd_word = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= rd_word;
    end
  end

  assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_input_pio_capture.sv
// Bench for input_pio_capture: three instances (rising, falling, any edge) checked against a
// history-based reference model; debounce scenario is added when PIO_DEBOUNCE_EN is defined.
`timescale 1ns/1ps
module tb_input_pio_capture;

  localparam int W  = 10;
  localparam int SS = 2;
  localparam int DB = 8;
`ifdef PIO_DEBOUNCE_EN
  localparam int FILT_LAT = SS + DB;
`else
  localparam int FILT_LAT = SS;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [1:0]    address = 2'd0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [31:0]   writedata = 32'd0;
  logic [W-1:0]  in_port = '0;
  logic [31:0]   rd [3];
  logic          irq_o [3];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    input_pio_capture #(
      .WIDTH(W), .EDGE_MODE(g), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB)
    ) u_dut (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_port),
      .readdata(rd[g]), .irq(irq_o[g])
    );
  end

  // Reference model: sync is in_port as sampled SS edges ago; edges are judged between
  // consecutive filtered values and recorded only after SS+1 cycles out of reset.
  logic [W-1:0] m_hist [SS];
  logic [W-1:0] m_prev;
  logic [W-1:0] m_mask;
  logic [W-1:0] m_filt_db;
  logic [W-1:0] m_ec [3];
  logic [31:0]  m_rd [3];
  int           m_cyc;
  int           m_run [W];

  task automatic model_reset();
    for (int k = 0; k < SS; k++) m_hist[k] = '0;
    for (int m = 0; m < 3; m++) begin
      m_ec[m] = '0;
      m_rd[m] = '0;
    end
    for (int i = 0; i < W; i++) m_run[i] = 0;
    m_prev    = '0;
    m_mask    = '0;
    m_filt_db = '0;
    m_cyc     = 0;
  endtask

  task automatic model_step();
    logic [W-1:0] sync_v;
    logic [W-1:0] filt_v;
    logic [W-1:0] clr;
    logic [W-1:0] e;
    logic         armed;
    logic         wr;
    if (!reset_n) return;
    sync_v = m_hist[SS-1];
`ifdef PIO_DEBOUNCE_EN
    filt_v = m_filt_db;
`else
    filt_v = sync_v;
`endif
    armed = (m_cyc > SS);
    wr    = chipselect && !write_n;
    clr   = (wr && address == 2'd3) ? writedata[W-1:0] : '0;
    for (int m = 0; m < 3; m++) begin
      case (address)
        2'd0:    m_rd[m] = 32'(filt_v);
        2'd2:    m_rd[m] = 32'(m_mask);
        2'd3:    m_rd[m] = 32'(m_ec[m]);
        default: m_rd[m] = 32'd0;
      endcase
      if (m == 0)      e = filt_v & ~m_prev;
      else if (m == 1) e = ~filt_v & m_prev;
      else             e = filt_v ^ m_prev;
      m_ec[m] = (m_ec[m] & ~clr) | (armed ? e : '0);
    end
    if (wr && address == 2'd2) m_mask = writedata[W-1:0];
    m_prev = filt_v;
`ifdef PIO_DEBOUNCE_EN
    for (int i = 0; i < W; i++) begin
      if (sync_v[i] != m_filt_db[i]) begin
        m_run[i]++;
        if (m_run[i] == DB) begin
          m_filt_db[i] = ~m_filt_db[i];
          m_run[i]     = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
`endif
    for (int k = SS - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = in_port;
    if (m_cyc < 1000) m_cyc++;
  endtask

  // Inputs change only at negedge; the model advances at the posedge it shares with the DUT.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic clear_all();
    bus_write(2'd3, 32'h3FF);
  endtask

  task automatic test_reset();
    in_port = W'($urandom);
    repeat (3) tick();
    for (int m = 0; m < 3; m++) begin
      checks++;
      if (rd[m] !== 32'd0 || irq_o[m] !== 1'b0) begin
        errors++;
        $display("FAIL reset_state mode%0d: readdata=%h irq=%b, expected 0/0", m, rd[m], irq_o[m]);
      end
    end
    reset_n = 1'b1;
    repeat (6) tick();
    bus_write(2'd2, 32'h3FF);
    in_port = ~in_port;
    tick();
    reset_n = 1'b0;
    model_reset();
    #1;
    for (int m = 0; m < 3; m++) begin
      checks++;
      if (rd[m] !== 32'd0 || irq_o[m] !== 1'b0) begin
        errors++;
        $display("FAIL async_reset mode%0d: readdata=%h irq=%b, expected 0/0", m, rd[m], irq_o[m]);
      end
    end
    @(negedge clk);
    reset_n = 1'b1;
    address = 2'd3;
    repeat (FILT_LAT + 4) tick();
    for (int m = 0; m < 3; m++) begin
      checks++;
      if (rd[m] !== m_rd[m] || irq_o[m] !== (|(m_ec[m] & m_mask))) begin
        errors++;
        $display("FAIL reset_midop mode%0d: readdata=%h irq=%b, expected readdata=%h irq=%b",
                 m, rd[m], irq_o[m], m_rd[m], |(m_ec[m] & m_mask));
      end
    end
  endtask

  task automatic test_data_read();
    address = 2'd0;
    in_port = 10'h2A5;
    repeat (FILT_LAT + 2) tick();
    for (int m = 0; m < 3; m++) begin
      checks++;
      if (rd[m] !== 32'h0000_02A5) begin
        errors++;
        $display("FAIL data_read mode%0d: readdata=%h, expected 000002a5", m, rd[m]);
      end
    end
    bus_write(2'd1, 32'hFFFF_FFFF);
    address = 2'd1;
    tick();
    for (int m = 0; m < 3; m++) begin
      checks++;
      if (rd[m] !== 32'd0) begin
        errors++;
        $display("FAIL reserved_read mode%0d: readdata=%h, expected 0", m, rd[m]);
      end
    end
    address = 2'd2;
    tick();
    checks++;
    if (rd[0] !== m_rd[0]) begin
      errors++;
      $display("FAIL mask_read: readdata=%h, expected %h", rd[0], m_rd[0]);
    end
  endtask

  task automatic test_rising();
    in_port = '0;
    repeat (FILT_LAT + 3) tick();
    clear_all();
    bus_write(2'd2, 32'h001);
    in_port = 10'h001;
    repeat (FILT_LAT + 1) tick();
    checks++;
    if (irq_o[0] !== 1'b1 || irq_o[1] !== 1'b0) begin
      errors++;
      $display("FAIL rise_irq: irq rise=%b fall=%b, expected 1/0", irq_o[0], irq_o[1]);
    end
    address = 2'd3;
    tick();
    checks++;
    if (rd[0] !== 32'h001) begin
      errors++;
      $display("FAIL rise_capture: edge_capture=%h, expected 00000001", rd[0]);
    end
    bus_write(2'd3, 32'h001);
    checks++;
    if (irq_o[0] !== 1'b0 || irq_o[2] !== 1'b0) begin
      errors++;
      $display("FAIL rise_clear: irq rise=%b any=%b, expected 0/0", irq_o[0], irq_o[2]);
    end
  endtask

  task automatic test_falling();
    bus_write(2'd2, 32'h000);
    in_port = 10'h008;
    repeat (FILT_LAT + 3) tick();
    clear_all();
    address = 2'd3;
    in_port = 10'h010;
    repeat (FILT_LAT + 2) tick();
    checks++;
    if (rd[1] !== 32'h008 || rd[0] !== 32'h010 || rd[2] !== 32'h018) begin
      errors++;
      $display("FAIL fall_capture: fall=%h rise=%h any=%h, expected 008/010/018", rd[1], rd[0], rd[2]);
    end
    for (int m = 0; m < 3; m++) begin
      checks++;
      if (irq_o[m] !== 1'b0) begin
        errors++;
        $display("FAIL fall_masked_irq mode%0d: irq=%b, expected 0", m, irq_o[m]);
      end
    end
  endtask

  task automatic test_set_wins();
    in_port = '0;
    repeat (FILT_LAT + 3) tick();
    clear_all();
    in_port = 10'h004;
    repeat (FILT_LAT + 2) tick();
    in_port = 10'h000;
    repeat (FILT_LAT + 2) tick();
    in_port = 10'h004;
    repeat (FILT_LAT) tick();
    bus_write(2'd3, 32'h004);
    address = 2'd3;
    tick();
    checks++;
    if (rd[0][2] !== 1'b1 || rd[2][2] !== 1'b1 || rd[1][2] !== 1'b0) begin
      errors++;
      $display("FAIL set_wins: bit2 rise=%b any=%b fall=%b, expected 1/1/0", rd[0][2], rd[2][2], rd[1][2]);
    end
    for (int m = 0; m < 3; m++) begin
      checks++;
      if (rd[m] !== m_rd[m]) begin
        errors++;
        $display("FAIL set_wins_model mode%0d: readdata=%h, expected %h", m, rd[m], m_rd[m]);
      end
    end
  endtask

  task automatic test_reset_high();
    in_port = 10'h3FF;
    tick();
    reset_n = 1'b0;
    model_reset();
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (FILT_LAT + 8) tick();
    bus_write(2'd2, 32'h3FF);
    address = 2'd3;
    repeat (2) tick();
    for (int m = 0; m < 3; m++) begin
      checks++;
      if (rd[m] !== m_rd[m] || irq_o[m] !== (|(m_ec[m] & m_mask))) begin
        errors++;
        $display("FAIL reset_high_model mode%0d: readdata=%h irq=%b, expected readdata=%h irq=%b",
                 m, rd[m], irq_o[m], m_rd[m], |(m_ec[m] & m_mask));
      end
`ifndef PIO_DEBOUNCE_EN
      checks++;
      if (rd[m] !== 32'd0 || irq_o[m] !== 1'b0) begin
        errors++;
        $display("FAIL reset_high mode%0d: edge_capture=%h irq=%b, expected 0/0", m, rd[m], irq_o[m]);
      end
`endif
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(3) == 0) in_port = in_port ^ W'($urandom);
      if ($urandom_range(5) == 0) begin
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = $urandom;
      end else begin
        chipselect = 1'($urandom_range(1));
        write_n    = chipselect ? 1'b1 : 1'($urandom_range(1));
      end
      address = 2'($urandom_range(3));
      tick();
      for (int m = 0; m < 3; m++) begin
        checks++;
        if (rd[m] !== m_rd[m] || irq_o[m] !== (|(m_ec[m] & m_mask))) begin
          errors++;
          $display("FAIL random mode%0d cycle%0d: readdata=%h irq=%b, expected readdata=%h irq=%b",
                   m, c, rd[m], irq_o[m], m_rd[m], |(m_ec[m] & m_mask));
        end
      end
    end
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

`ifdef PIO_DEBOUNCE_EN
  task automatic test_debounce();
    address = 2'd0;
    in_port = '0;
    repeat (FILT_LAT + 3) tick();
    clear_all();
    bus_write(2'd2, 32'h3FF);
    address = 2'd0;
    in_port = 10'h002;
    repeat (5) tick();
    in_port = 10'h000;
    for (int c = 0; c < FILT_LAT + 4; c++) begin
      tick();
      checks++;
      if (rd[0][1] !== 1'b0 || irq_o[0] !== 1'b0) begin
        errors++;
        $display("FAIL debounce_glitch cycle%0d: filt1=%b irq=%b, expected 0/0", c, rd[0][1], irq_o[0]);
      end
    end
    in_port = 10'h002;
    repeat (FILT_LAT + 3) tick();
    checks++;
    if (rd[0][1] !== 1'b1 || irq_o[0] !== 1'b1) begin
      errors++;
      $display("FAIL debounce_level: filt1=%b irq=%b, expected 1/1", rd[0][1], irq_o[0]);
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_data_read();
    test_rising();
    test_falling();
    test_set_wins();
    test_reset_high();
    test_random();
`ifdef PIO_DEBOUNCE_EN
    test_debounce();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
